// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver feeding a one-entry AXI-Stream output register.
// Optional parity bit, odd/even via PARITY_ODD, and parity_error port: define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_stream_tdata,
  output logic       rx_stream_tvalid,
  input  logic       rx_stream_tready,
  output logic       framing_error,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_error
`endif
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW      = $clog2(OVERSAMPLE);
  localparam int unsigned MID     = OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST    = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state;
  logic [1:0]      sync;
  logic            line;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [SW-1:0]   samp;
  logic            sample;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic            armed;
`ifdef UART_RX_PARITY_EN
  logic            par_bad;
`endif

  assign line = sync[1];
  assign tick = (state != IDLE) && (tick_cnt == TW'(DIV - 1));
  // Start bit is checked at its centre; the counter is then cleared so data bits sample on the wrap.
  assign sample = tick && (samp == ((state == START) ? SW'(MID) : SW'(LAST)));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync             <= 2'b11;
      state            <= IDLE;
      tick_cnt         <= '0;
      samp             <= '0;
      bit_idx          <= '0;
      shift_reg        <= '0;
      armed            <= 1'b0;
      rx_stream_tdata  <= '0;
      rx_stream_tvalid <= 1'b0;
      framing_error    <= 1'b0;
      overrun          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad          <= 1'b0;
      parity_error     <= 1'b0;
`endif
    end else begin
      sync          <= {sync[0], rxd};
      framing_error <= 1'b0;
      overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      if (rx_stream_tvalid && rx_stream_tready) rx_stream_tvalid <= 1'b0;

      if (state == IDLE || tick) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + TW'(1);

      if (state == IDLE) samp <= '0;
      else if (tick)     samp <= (samp == SW'(LAST)) ? '0 : samp + SW'(1);

      case (state)
        IDLE: begin
          // A new start needs the line to have been high since the last frame ended.
          if (line) armed <= 1'b1;
          if (armed && !line) state <= START;
        end
        START: begin
          if (sample) begin
            if (line) begin
              state <= IDLE;
            end else begin
              samp    <= '0;
              bit_idx <= '0;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shift_reg[bit_idx] <= line;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample) begin
            par_bad <= line ^ (^shift_reg) ^ PARITY_ODD;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (sample) begin
            state <= IDLE;
            if (!line) begin
              framing_error <= 1'b1;
              armed         <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_bad) begin
              parity_error <= 1'b1;
            end
`endif
            else if (!rx_stream_tvalid || rx_stream_tready) begin
              rx_stream_tdata  <= shift_reg;
              rx_stream_tvalid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level model of uart_rx checked every cycle, plus literal pins on latency and data.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned OS       = 16;
  localparam int          BIT_CLKS = int'(CLK_FREQ / BAUD);
`ifdef UART_RX_PARITY_EN
  localparam int          NBITS    = 11;
  localparam int          LAT_LIT  = 170;
`else
  localparam int          NBITS    = 10;
  localparam int          LAT_LIT  = 154;
`endif
  // rxd edge to tvalid: 2 sync flops, half a bit to the start centre, then whole bits to the stop centre
  localparam int          LAT      = 2 + int'(OS / 2) + (NBITS - 1) * BIT_CLKS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       tready = 1'b1;
  logic [7:0] tdata;
  logic       tvalid;
  logic       framing_error;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
  bit         par_flip = 1'b0;
  int         pe_cnt = 0;
`endif

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rxd             (rxd),
    .rx_stream_tdata (tdata),
    .rx_stream_tvalid(tvalid),
    .rx_stream_tready(tready),
    .framing_error   (framing_error),
    .overrun         (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error    (parity_error)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         good;
    bit         perr;
    logic [7:0] b;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [7:0] b;
  } rise_t;

  ev_t   evq[$];
  rise_t seen[$];
  int    checks = 0;
  int    errors = 0;
  int    fe_cnt = 0;
  int    ov_cnt = 0;
  int    last_fall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: one pending-byte register driven by frame completions and handshakes.
  initial begin : compare
    bit         m_valid;
    logic [7:0] m_data;
    logic       prev_valid;
    bit         e_fe, e_ov;
`ifdef UART_RX_PARITY_EN
    bit         e_pe;
`endif
    ev_t        e;
    m_valid    = 1'b0;
    m_data     = '0;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      e_fe = 1'b0;
      e_ov = 1'b0;
`ifdef UART_RX_PARITY_EN
      e_pe = 1'b0;
`endif
      if (reset) begin
        m_valid = 1'b0;
        evq.delete();
        check("tdata_reset", 32'(tdata), 32'h0);
      end else begin
        if (m_valid && tready) m_valid = 1'b0;
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          e = evq.pop_front();
          if (!e.good) begin
`ifdef UART_RX_PARITY_EN
            if (e.perr) e_pe = 1'b1;
            else
`endif
            e_fe = 1'b1;
          end else if (m_valid) begin
            e_ov = 1'b1;
          end else begin
            m_valid = 1'b1;
            m_data  = e.b;
          end
        end
      end
      check("tvalid", 32'(tvalid), 32'(m_valid));
      if (m_valid) check("tdata", 32'(tdata), 32'(m_data));
      check("framing_error", 32'(framing_error), 32'(e_fe));
      check("overrun", 32'(overrun), 32'(e_ov));
`ifdef UART_RX_PARITY_EN
      check("parity_error", 32'(parity_error), 32'(e_pe));
      if (parity_error === 1'b1) pe_cnt++;
`endif
      if (framing_error === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (tvalid === 1'b1 && prev_valid !== 1'b1) seen.push_back('{cyc, tdata});
      prev_valid = tvalid;
    end
  end

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    ev_t e;
    e.good = stop_ok;
    e.perr = 1'b0;
    e.b    = b;
`ifdef UART_RX_PARITY_EN
    if (stop_ok && par_flip) begin
      e.good = 1'b0;
      e.perr = 1'b1;
    end
`endif
    last_fall = cyc + 1;
    e.cyc     = last_fall + LAT;
    evq.push_back(e);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(b[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    hold((^b) ^ par_flip, BIT_CLKS);
`endif
    hold(stop_ok, BIT_CLKS);
    rxd = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int f;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hold(1'b1, 5);

    // single byte, latency pinned by literal
    seen.delete();
    send(8'hA5, 1'b1);
    f = last_fall;
    hold(1'b1, 40);
    check("single_count", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) begin
      check("single_latency", 32'(seen[0].cyc - f), 32'(LAT_LIT));
      check("single_data", 32'(seen[0].b), 32'hA5);
    end

    // back-to-back frames
    seen.delete();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h3C, 1'b1);
    hold(1'b1, 40);
    check("b2b_count", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      check("b2b_0", 32'(seen[0].b), 32'h00);
      check("b2b_1", 32'(seen[1].b), 32'hFF);
      check("b2b_2", 32'(seen[2].b), 32'h3C);
    end

    // backpressure and overrun
    seen.delete();
    tready = 1'b0;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    hold(1'b1, 40);
    check("bp_tvalid", 32'(tvalid), 32'd1);
    check("bp_tdata", 32'(tdata), 32'h11);
    check("bp_overrun_count", 32'(ov_cnt), 32'd1);
    tready = 1'b1;
    hold(1'b1, 40);
    check("bp_rises", 32'(seen.size()), 32'd1);
    check("bp_drained", 32'(tvalid), 32'd0);

    // framing error then recovery
    seen.delete();
    send(8'h5A, 1'b0);
    hold(1'b1, 40);
    check("fe_count", 32'(fe_cnt), 32'd1);
    check("fe_no_data", 32'(seen.size()), 32'd0);
    send(8'h5A, 1'b1);
    hold(1'b1, 40);
    check("fe_recover_count", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) check("fe_recover_data", 32'(seen[0].b), 32'h5A);

    // glitch on the line
    seen.delete();
    hold(1'b0, 4);
    hold(1'b1, 200);
    check("glitch_no_data", 32'(seen.size()), 32'd0);

    // reset in the middle of 0xC3
    hold(1'b0, BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    hold(1'b0, 8);
    reset = 1'b1;
    hold(1'b1, 3);
    reset = 1'b0;
    hold(1'b1, 200);
    check("reset_no_data", 32'(seen.size()), 32'd0);
    check("reset_no_fe", 32'(fe_cnt), 32'd1);
    send(8'h81, 1'b1);
    hold(1'b1, 40);
    check("after_reset_count", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) check("after_reset_data", 32'(seen[0].b), 32'h81);

`ifdef UART_RX_PARITY_EN
    // even parity: 0x07 carries parity bit 1
    seen.delete();
    par_flip = 1'b0;
    send(8'h07, 1'b1);
    hold(1'b1, 40);
    check("par_good_count", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) check("par_good_data", 32'(seen[0].b), 32'h07);
    par_flip = 1'b1;
    send(8'h07, 1'b1);
    hold(1'b1, 40);
    par_flip = 1'b0;
    check("par_bad_pulse", 32'(pe_cnt), 32'd1);
    check("par_bad_no_data", 32'(seen.size()), 32'd1);
`endif

    check("queue_drained", 32'(evq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
